// File: rtl/keypad_entry.sv
// keypad_entry: assembles a fixed-length numeric code from debounced keypad
// levels and offers it downstream with a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   key_code     digit value presented by the keypad (0..9 accepted)
//   key_press    level, high while a digit key is held
//   key_enter    level, high while the enter key is held
//   key_clear    level, high while the clear key is held
//   code_ready   downstream comparator can accept a code
//   code         assembled code, first-entered digit in the MSBs
//   code_valid   code holds a complete code offered downstream
//   digit_count  digits accepted so far
//   entry_error  one-cycle pulse for a rejected key event
//   timeout      one-cycle pulse for an abandoned entry
//
// Optional feature: define KEYPAD_ENTRY_TIMEOUT_EN to abandon an entry after
// TIMEOUT_CYCLES cycles in COLLECT without a key edge. Without it, timeout
// is tied low and an entry waits indefinitely.
module keypad_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              key_code,
  input  logic                    key_press,
  input  logic                    key_enter,
  input  logic                    key_clear,
  input  logic                    code_ready,
  output logic [NUM_DIGITS*4-1:0] code,
  output logic                    code_valid,
  output logic [3:0]              digit_count,
  output logic                    entry_error,
  output logic                    timeout
);

  localparam int W = NUM_DIGITS * 4;

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  state_t         state, state_n;
  logic [W-1:0]   code_n;
  logic [3:0]     count_n;
  logic           valid_n, error_n;

  // Key levels as {clear, enter, press}: key_q is the sampled level, key_qq
  // the level one cycle earlier. primed is low only for the first cycle after
  // reset, when key_qq is loaded with the raw level so a key held through
  // reset release does not look like a fresh press.
  logic [2:0]     key_q, key_qq;
  logic [3:0]     key_code_q;
  logic           primed;
  logic           clr_e, ent_e, dig_e, to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q      <= '0;
      key_qq     <= '0;
      key_code_q <= '0;
      primed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      key_q      <= {key_clear, key_enter, key_press};
      key_qq     <= primed ? key_q : {key_clear, key_enter, key_press};
      key_code_q <= key_code;
      primed     <= 1'b1;
    end
  end

  assign clr_e = key_q[2] & ~key_qq[2];
  assign ent_e = key_q[1] & ~key_qq[1];
  assign dig_e = key_q[0] & ~key_qq[0];

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_cnt, idle_cnt_n;

  // The counter reads TIMEOUT_CYCLES-1 after that many quiet cycles, so the
  // abandon happens on the TIMEOUT_CYCLES-th quiet edge.
  assign to_hit = (state == COLLECT) && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_cnt_n = idle_cnt + 1'b1;
    if (state != COLLECT || clr_e || ent_e || dig_e || to_hit) idle_cnt_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_n;
      timeout  <= to_hit;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    state_n = state;
    code_n  = code;
    count_n = digit_count;
    valid_n = code_valid;
    error_n = 1'b0;

    case (state)
      PRESENT: begin
        // Key edges are ignored here; only the handshake ends the offer.
        if (code_ready) begin
          state_n = IDLE;
          code_n  = '0;
          count_n = '0;
          valid_n = 1'b0;
        end
      end
      default: begin
        // Priority: timeout > clear > enter > digit; losers are dropped.
        if (to_hit || clr_e) begin
          state_n = IDLE;
          code_n  = '0;
          count_n = '0;
        end else if (ent_e) begin
          if (state == COLLECT && digit_count == 4'(NUM_DIGITS)) begin
            state_n = PRESENT;
            valid_n = 1'b1;
          end else begin
            state_n = IDLE;
            code_n  = '0;
            count_n = '0;
            error_n = 1'b1;
          end
        end else if (dig_e) begin
          if (key_code_q > 4'd9 || digit_count == 4'(NUM_DIGITS)) begin
            error_n = 1'b1;
          end else begin
            state_n = COLLECT;
            code_n  = (code << 4) | W'(key_code_q);
            count_n = digit_count + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      code        <= '0;
      digit_count <= '0;
      code_valid  <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      code        <= code_n;
      digit_count <= count_n;
      code_valid  <= valid_n;
      entry_error <= error_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry (NUM_DIGITS = 4, TIMEOUT_CYCLES = 10).
// Expected codes are queued when enter is driven and compared when the DUT
// completes a transfer; event counters are compared against per-scenario
// expectations.
module tb_keypad_entry;

  localparam int ND = 4;
  localparam int TC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    key_code;
  logic          key_press, key_enter, key_clear, code_ready;
  logic [ND*4-1:0] code;
  logic          code_valid, entry_error, timeout;
  logic [3:0]    digit_count;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0, to_cnt = 0, valid_cyc = 0, xfer_cnt = 0;
  logic [ND*4-1:0] exp_q[$];

  keypad_entry #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_code    (key_code),
    .key_press   (key_press),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .code_ready  (code_ready),
    .code        (code),
    .code_valid  (code_valid),
    .digit_count (digit_count),
    .entry_error (entry_error),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (entry_error) err_cnt++;
      if (timeout)     to_cnt++;
      if (code_valid)  valid_cyc++;
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 32'(code), 32'hDEAD_BEEF);
        else                   check("xfer_code", 32'(code), 32'(exp_q.pop_front()));
        xfer_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_digit(input logic [3:0] d);
    key_code  = d;
    key_press = 1'b1;
    tick(2);
    key_press = 1'b0;
    tick(2);
  endtask

  task automatic press_enter();
    key_enter = 1'b1;
    tick(2);
    key_enter = 1'b0;
    tick(2);
  endtask

  task automatic press_clear();
    key_clear = 1'b1;
    tick(2);
    key_clear = 1'b0;
    tick(2);
  endtask

  task automatic wait_xfer(input int target);
    for (int i = 0; i < 20 && xfer_cnt < target; i++) tick();
    check("xfer_count", 32'(xfer_cnt), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, v0, t0, bad;
    reset = 1'b1; key_code = 4'd0; key_press = 1'b1; key_enter = 1'b0;
    key_clear = 1'b0; code_ready = 1'b1;

    // Reset state, with a digit key held through reset release.
    tick(3);
    check("rst_code",  32'(code), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_valid", 32'(code_valid), 32'h0);
    check("rst_err",   32'(entry_error), 32'h0);
    check("rst_to",    32'(timeout), 32'h0);
    reset = 1'b0;
    tick(4);
    check("held_key_count", 32'(digit_count), 32'h0);
    check("held_key_err",   32'(err_cnt), 32'h0);
    key_press = 1'b0;
    tick(2);

    // 1,2,3,4 + enter with code_ready high; first digit checks latency.
    v0 = valid_cyc;
    key_code = 4'd1; key_press = 1'b1;
    tick(1);
    check("lat_edge_n",  32'(digit_count), 32'h0);
    tick(1);
    check("lat_edge_n1", 32'(digit_count), 32'h1);
    check("lat_code",    32'(code), 32'h1);
    key_press = 1'b0;
    tick(2);
    press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
    check("s1_code",  32'(code), 32'h1234);
    check("s1_count", 32'(digit_count), 32'h4);
    exp_q.push_back(16'h1234);
    press_enter();
    wait_xfer(1);
    check("s1_valid_cycles", 32'(valid_cyc - v0), 32'h1);
    check("s1_count_after",  32'(digit_count), 32'h0);
    check("s1_code_after",   32'(code), 32'h0);

    // Short code: 5,6 + enter.
    e0 = err_cnt; v0 = valid_cyc;
    press_digit(4'd5); press_digit(4'd6);
    press_enter();
    check("s2_err",   32'(err_cnt - e0), 32'h1);
    check("s2_code",  32'(code), 32'h0);
    check("s2_count", 32'(digit_count), 32'h0);
    check("s2_valid", 32'(valid_cyc - v0), 32'h0);

    // Invalid key then five 9s.
    e0 = err_cnt;
    press_digit(4'hB);
    check("s3_bad_count", 32'(digit_count), 32'h0);
    for (int i = 0; i < 5; i++) press_digit(4'd9);
    check("s3_err",   32'(err_cnt - e0), 32'h2);
    check("s3_count", 32'(digit_count), 32'h4);
    check("s3_code",  32'(code), 32'h9999);
    exp_q.push_back(16'h9999);
    press_enter();
    wait_xfer(2);

    // Full code held while code_ready low; keys ignored in PRESENT.
    code_ready = 1'b0;
    press_digit(4'd2); press_digit(4'd0); press_digit(4'd2); press_digit(4'd5);
    exp_q.push_back(16'h2025);
    press_enter();
    check("s4_valid", 32'(code_valid), 32'h1);
    check("s4_code",  32'(code), 32'h2025);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      key_code  = 4'(i % 10);
      key_press = (i % 4) >= 2;
      key_clear = (i == 9);
      tick();
      if (code_valid !== 1'b1 || code !== 16'h2025 || digit_count !== 4'd4) bad++;
    end
    check("s4_stable", 32'(bad), 32'h0);
    key_press = 1'b0; key_clear = 1'b0;
    tick(2);
    check("s4_no_early_xfer", 32'(xfer_cnt), 32'h2);
    code_ready = 1'b1;
    wait_xfer(3);
    tick(1);
    check("s4_count_after", 32'(digit_count), 32'h0);
    check("s4_queue_empty", 32'(exp_q.size()), 32'h0);

    // Clear beats digit; enter beats digit.
    press_digit(4'd7); press_digit(4'd8);
    check("s5_count_pre", 32'(digit_count), 32'h2);
    e0 = err_cnt;
    key_code = 4'd1; key_press = 1'b1; key_clear = 1'b1;
    tick(2);
    key_press = 1'b0; key_clear = 1'b0;
    tick(2);
    check("s5_count", 32'(digit_count), 32'h0);
    check("s5_code",  32'(code), 32'h0);
    check("s5_err",   32'(err_cnt - e0), 32'h0);
    key_press = 1'b1; key_enter = 1'b1;
    tick(2);
    key_press = 1'b0; key_enter = 1'b0;
    tick(2);
    check("s5_enter_prio_count", 32'(digit_count), 32'h0);
    check("s5_enter_prio_err",   32'(err_cnt - e0), 32'h1);

    // Inactivity in COLLECT.
    t0 = to_cnt;
    press_digit(4'd3);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    tick(7);
    check("to_early_count", 32'(digit_count), 32'h1);
    tick(1);
    check("to_pulse",       32'(timeout), 32'h1);
    check("to_count",       32'(digit_count), 32'h0);
    tick(1);
    check("to_pulse_end",   32'(timeout), 32'h0);
    check("to_pulses",      32'(to_cnt - t0), 32'h1);
`else
    tick(30);
    check("no_to_count",  32'(digit_count), 32'h1);
    check("no_to_pulses", 32'(to_cnt - t0), 32'h0);
    press_clear();
`endif

    // Reset asserted mid-entry takes effect before the next clock edge.
    press_digit(4'd1); press_digit(4'd2);
    check("s7_count_pre", 32'(digit_count), 32'h2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("s7_code",  32'(code), 32'h0);
    check("s7_count", 32'(digit_count), 32'h0);
    check("s7_valid", 32'(code_valid), 32'h0);
    check("s7_err",   32'(entry_error), 32'h0);
    check("s7_to",    32'(timeout), 32'h0);
    key_code = 4'd5; key_press = 1'b1;
    tick(2);
    e0 = err_cnt;
    reset = 1'b0;
    tick(4);
    check("s7_held_count", 32'(digit_count), 32'h0);
    check("s7_held_err",   32'(err_cnt - e0), 32'h0);
    key_press = 1'b0;
    tick(2);
    press_digit(4'd4);
    check("s7_resume_code", 32'(code), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of 4-bit digits per code, legal range 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the idle cycles allowed between keys before the entry is abandoned, legal value >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key_code, input, 4 bits: the digit value presented by the keypad.
REQ-006 SHALL have port key_press, input, 1 bit: a level that is high while a digit key is held.
REQ-007 SHALL have port key_enter, input, 1 bit: a level that is high while the enter key is held.
REQ-008 SHALL have port key_clear, input, 1 bit: a level that is high while the clear key is held.
REQ-009 SHALL have port code_ready, input, 1 bit: asserted by the downstream comparator when it can accept a code.
REQ-010 SHALL have port code, output, NUM_DIGITS*4 bits: the assembled code, first-entered digit in the MSBs.
REQ-011 SHALL have port code_valid, output, 1 bit: high while code holds a complete code offered downstream.
REQ-012 SHALL have port digit_count, output, 4 bits: the number of digits accepted so far.
REQ-013 SHALL have port entry_error, output, 1 bit: a one-cycle pulse flagging a rejected key event.
REQ-014 SHALL have port timeout, output, 1 bit: a one-cycle pulse flagging an abandoned entry.

Function
REQ-015 SHALL register key_press, key_enter and key_clear each cycle and act only on rising edges (current 1, previous 0); a held key generates exactly one event.
REQ-016 SHALL implement states IDLE, COLLECT and PRESENT.
REQ-017 SHALL, on an accepted digit edge sampled at edge n, make code = {code[W-5:0], key_code} and digit_count+1 visible after edge n+1, and enter COLLECT from IDLE.
REQ-018 SHALL accept only key_code values 0..9; values 10..15 SHALL leave code and digit_count unchanged and pulse entry_error.
REQ-019 SHALL, for a digit edge when digit_count == NUM_DIGITS, ignore the digit and pulse entry_error.
REQ-020 SHALL, on an enter edge in COLLECT with digit_count == NUM_DIGITS, go to PRESENT with code_valid = 1 on the next cycle.
REQ-021 SHALL, on an enter edge with digit_count < NUM_DIGITS (including in IDLE), pulse entry_error, clear code and digit_count to 0, and go to IDLE.
REQ-022 SHALL, on a clear edge in IDLE or COLLECT, zero code and digit_count and go to IDLE with no error pulse.
REQ-023 SHALL give events same-cycle priority clear > enter > digit; the losing events are discarded.
REQ-024 SHALL, in PRESENT, hold code and code_valid stable and ignore all key edges while continuing edge tracking.
REQ-025 SHALL complete a transfer on a rising edge with code_valid && code_ready, after which code_valid = 0, code = 0, digit_count = 0 and the state is IDLE.
REQ-026 SHALL hold code_valid indefinitely while code_ready is low; code_ready while code_valid is low SHALL have no effect.

Reset
REQ-027 SHALL, while reset = 1 and regardless of clk, force IDLE with code = 0, code_valid = 0, digit_count = 0, entry_error = 0, timeout = 0, the idle counter = 0 and the edge registers = 0.
REQ-028 SHALL discard any partial entry or pending code on reset; a key held through reset release SHALL NOT generate an event.

Configuration
REQ-029 SHALL, with macro KEYPAD_ENTRY_TIMEOUT_EN defined, count cycles in COLLECT, reset the count on every accepted or rejected key edge, and on reaching TIMEOUT_CYCLES zero code and digit_count, pulse timeout and go to IDLE; a key edge in that same cycle is discarded.
REQ-030 SHALL, without KEYPAD_ENTRY_TIMEOUT_EN, omit the counter, tie timeout to 0 and never leave COLLECT for lack of activity.

Verification
REQ-031 SHALL cover: digits 1,2,3,4 then enter, code_ready = 1 -> code = 16'h1234, code_valid high for one cycle, digit_count returns to 0.
REQ-032 SHALL cover: digits 5,6 then enter -> entry_error pulse, code = 0, state IDLE, code_valid never asserted.
REQ-033 SHALL cover: key_code = 4'hB pressed, then five digits 9 -> two entry_error pulses in total, code = 16'h9999 after enter.
REQ-034 SHALL cover: full code entered with code_ready = 0 for 20 cycles while digits are pressed -> code_valid and code stable, digits ignored, transfer on code_ready = 1.
REQ-035 SHALL cover: digit edge and clear edge in the same cycle after digits 7,8 -> digit_count = 0, code = 0, no entry_error.
REQ-036 SHALL cover, with KEYPAD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES = 10: digit 3 then 10 idle cycles -> timeout pulse, digit_count = 0; reset asserted mid-entry -> all outputs 0 immediately.
